boolean_function_sequencer: RTL and testbench

//  Drives a combinational N_IN-input boolean function block through all 2^N_IN input

---
 rtl/boolean_function_sequencer_pkg.sv | 28 ++
 rtl/boolean_function_sequencer_if.sv | 38 +++
 rtl/boolean_function_sequencer_settle_timer.sv | 29 ++
 rtl/boolean_function_sequencer.sv | 128 ++++++++++++
 tb/tb_boolean_function_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/boolean_function_sequencer_pkg.sv
// Shared types and helpers for the boolean function sequencer.
// State encodings and counter-width helper used by the top and the settle timer.
package bf_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width able to hold values 0..n, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/boolean_function_sequencer_if.sv
// Handshake and function-block bus of the boolean function sequencer.
// Optional golden-table compare signals exist only when TT_CHECK_EN is defined.
interface boolean_function_sequencer_if #(
    parameter int unsigned N_IN = 3
);
    localparam int unsigned N_VEC = 1 << N_IN;

    logic             start;
    logic [N_IN-1:0]  fn_in;
    logic             fn_out;
    logic             busy;
    logic             done;
    logic [N_VEC-1:0] truth_table;
`ifdef TT_CHECK_EN
    logic [N_VEC-1:0] expected_tt;
    logic             mismatch;

    modport master (
        input  start, fn_out, expected_tt,
        output fn_in, busy, done, truth_table, mismatch
    );

    modport slave (
        output start, fn_out, expected_tt,
        input  fn_in, busy, done, truth_table, mismatch
    );
`else
    modport master (
        input  start, fn_out,
        output fn_in, busy, done, truth_table
    );

    modport slave (
        output start, fn_out,
        input  fn_in, busy, done, truth_table
    );
`endif
endinterface

// File: rtl/boolean_function_sequencer_settle_timer.sv
// Settle-interval counter: load clears, enable counts, expire flags the last settle cycle.
module bf_settle_timer
    import bf_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire_c
);
    localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire_c = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/boolean_function_sequencer.sv
// Walks a combinational function block through every input vector and records its truth table.
// Optional macro TT_CHECK_EN adds a golden-table compare producing a registered mismatch flag.
module boolean_function_sequencer
    import bf_seq_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    boolean_function_sequencer_if.master bus
);
    localparam int unsigned N_VEC = 1 << N_IN;

    state_e           r_state, w_state_nxt;
    logic [N_IN-1:0]  r_idx, w_idx_nxt, w_idx_inc;
    logic [N_IN-1:0]  r_fn_in, w_fn_in_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [N_VEC-1:0] r_tt, w_tt_nxt;
    logic             w_load, w_en, w_expire;
`ifdef TT_CHECK_EN
    logic             r_mismatch, w_mismatch_nxt;
`endif

    bf_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_en       (w_en),
        .o_expire_c (w_expire)
    );

    assign w_idx_inc = r_idx + N_IN'(1);

    // Next-state and next-output logic; registered outputs are computed here
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fn_in_nxt = r_fn_in;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_tt_nxt    = r_tt;
        w_load      = 1'b0;
        w_en        = 1'b0;
`ifdef TT_CHECK_EN
        w_mismatch_nxt = r_mismatch;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_tt_nxt    = '0;
                    w_idx_nxt   = '0;
                    w_fn_in_nxt = '0;
                    w_load      = 1'b1;
                    w_busy_nxt  = 1'b1;
`ifdef TT_CHECK_EN
                    w_mismatch_nxt = 1'b0;
`endif
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_en = 1'b1;
                if (w_expire) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_tt_nxt[r_idx] = bus.fn_out;
                if (r_idx == N_IN'(N_VEC - 1)) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
`ifdef TT_CHECK_EN
                    w_mismatch_nxt = |(w_tt_nxt ^ bus.expected_tt);
`endif
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt   = w_idx_inc;
                    w_fn_in_nxt = w_idx_inc;
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_fn_in <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tt    <= '0;
`ifdef TT_CHECK_EN
            r_mismatch <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_fn_in <= w_fn_in_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_tt    <= w_tt_nxt;
`ifdef TT_CHECK_EN
            r_mismatch <= w_mismatch_nxt;
`endif
        end
    end

    assign bus.fn_in       = r_fn_in;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.truth_table = r_tt;
`ifdef TT_CHECK_EN
    assign bus.mismatch    = r_mismatch;
`endif

endmodule

// File: tb/tb_boolean_function_sequencer.sv
// Randomized self-checking bench: two sequencers (settle 2 and settle 1) driving a table-lookup function.
// With TT_CHECK_EN defined it also checks the mismatch flag against a golden table.
module tb_boolean_function_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] fn_tt;
    bit         sel_b;
    int         n_checks;
    int         n_errors;
`ifdef TT_CHECK_EN
    logic [7:0] golden_tt;
`endif

    boolean_function_sequencer_if #(.N_IN(3)) bus_a ();
    boolean_function_sequencer_if #(.N_IN(3)) bus_b ();

    boolean_function_sequencer #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    boolean_function_sequencer #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // The "function block": a lookup into the current truth table
    assign bus_a.fn_out = fn_tt[bus_a.fn_in];
    assign bus_b.fn_out = fn_tt[bus_b.fn_in];
`ifdef TT_CHECK_EN
    assign bus_a.expected_tt = golden_tt;
    assign bus_b.expected_tt = golden_tt;
`endif

    logic       w_busy, w_done;
    logic [2:0] w_fn_in;
    logic [7:0] w_tt;
    assign w_busy  = sel_b ? bus_b.busy        : bus_a.busy;
    assign w_done  = sel_b ? bus_b.done        : bus_a.done;
    assign w_fn_in = sel_b ? bus_b.fn_in       : bus_a.fn_in;
    assign w_tt    = sel_b ? bus_b.truth_table : bus_a.truth_table;
`ifdef TT_CHECK_EN
    logic w_mm;
    assign w_mm = sel_b ? bus_b.mismatch : bus_a.mismatch;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_start(input bit use_b, input logic v);
        if (use_b) bus_b.start = v;
        else       bus_a.start = v;
    endtask

    // Reference table of a named function: kind 0 = a^b^c, kind 1 = a&b|c
    function automatic logic [7:0] table_of(input int kind);
        logic [7:0] t;
        int a, b, c;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            a = (i >> 2) & 1;
            b = (i >> 1) & 1;
            c = i & 1;
            if (kind == 0) t[i] = 1'((a + b + c) % 2);
            else           t[i] = 1'((a * b) | c);
        end
        return t;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_fn_in"}, 32'(bus_a.fn_in), 0);
        chk({tag, "_a_busy"},  32'(bus_a.busy), 0);
        chk({tag, "_a_done"},  32'(bus_a.done), 0);
        chk({tag, "_a_tt"},    32'(bus_a.truth_table), 0);
        chk({tag, "_b_fn_in"}, 32'(bus_b.fn_in), 0);
        chk({tag, "_b_busy"},  32'(bus_b.busy), 0);
        chk({tag, "_b_done"},  32'(bus_b.done), 0);
        chk({tag, "_b_tt"},    32'(bus_b.truth_table), 0);
`ifdef TT_CHECK_EN
        chk({tag, "_a_mm"},    32'(bus_a.mismatch), 0);
        chk({tag, "_b_mm"},    32'(bus_b.mismatch), 0);
`endif
    endtask

    // One full scan; extra start pulses at cycles ig1/ig2 must be ignored
    task automatic scan(input bit use_b, input logic [7:0] func, input logic [7:0] exp_tt,
                        input int ig1, input int ig2);
        int s, lat;
        s   = use_b ? 1 : 2;
        lat = (s + 1) * 8;
        sel_b = use_b;
        fn_tt = func;
        @(negedge clk);
        set_start(use_b, 1'b1);
        @(posedge clk); #1;
        set_start(use_b, 1'b0);
        chk("start_busy",  32'(w_busy), 1);
        chk("start_done",  32'(w_done), 0);
        chk("start_fn_in", 32'(w_fn_in), 0);
`ifdef TT_CHECK_EN
        chk("start_mm_clear", 32'(w_mm), 0);
`endif
        for (int k = 1; k <= lat; k++) begin
            if (k == ig1 || k == ig2) set_start(use_b, 1'b1);
            @(posedge clk); #1;
            set_start(use_b, 1'b0);
            if (k < lat) begin
                chk("scan_busy",  32'(w_busy), 1);
                chk("scan_done",  32'(w_done), 0);
                chk("scan_fn_in", 32'(w_fn_in), 32'(k / (s + 1)));
            end else begin
                chk("done_pulse", 32'(w_done), 1);
                chk("done_busy",  32'(w_busy), 0);
                chk("done_fn_in", 32'(w_fn_in), 7);
                chk("done_tt",    32'(w_tt), 32'(exp_tt));
`ifdef TT_CHECK_EN
                chk("done_mm",    32'(w_mm), 32'(exp_tt != golden_tt));
`endif
            end
        end
        @(posedge clk); #1;
        chk("post_done",  32'(w_done), 0);
        chk("post_busy",  32'(w_busy), 0);
        chk("post_tt",    32'(w_tt), 32'(exp_tt));
        chk("post_fn_in", 32'(w_fn_in), 7);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] f;
        bit         ub;
        bit         seen;
        int         lat;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        fn_tt       = '0;
        sel_b       = 1'b0;
`ifdef TT_CHECK_EN
        golden_tt   = '0;
`endif
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Reset asserted while idle
        #3 rst_n = 1'b0;
        #1 check_all_zero("idle_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 check_all_zero("idle_rel");

        // Parity function, then ignored starts at cycles 5 and 20, then a repeat scan
`ifdef TT_CHECK_EN
        golden_tt = 8'h96;
`endif
        scan(1'b0, table_of(0), 8'h96, -1, -1);
        scan(1'b0, table_of(0), 8'h96, 5, 20);

        // Settle of one cycle, a&b|c
`ifdef TT_CHECK_EN
        golden_tt = 8'hEA;
`endif
        scan(1'b1, table_of(1), 8'hEA, -1, -1);

`ifdef TT_CHECK_EN
        // Wrong golden table flags mismatch; the next accepted start clears it
        golden_tt = 8'h97;
        scan(1'b0, table_of(0), 8'h96, -1, -1);
        golden_tt = 8'h96;
        scan(1'b0, table_of(0), 8'h96, -1, -1);
`endif

        // Reset in the middle of a scan at idx 3
        sel_b = 1'b0;
        fn_tt = table_of(0);
        @(negedge clk) bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (bus_a.fn_in == 3'd3) seen = 1'b1;
        end
        chk("reach_idx3", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus_a.done || bus_b.done) seen = 1'b1;
        end
        chk("no_done_in_rst", 32'(seen), 0);
        @(negedge clk) rst_n = 1'b1;
        scan(1'b0, table_of(0), 8'h96, -1, -1);

        // start held high: next scan begins on the first idle cycle after done
        sel_b = 1'b0;
        fn_tt = table_of(1);
`ifdef TT_CHECK_EN
        golden_tt = 8'hEA;
`endif
        @(negedge clk) bus_a.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk); #1;
            if (k == 24) chk("held_done", 32'(bus_a.done), 1);
            if (k == 25) chk("held_idle_busy", 32'(bus_a.busy), 0);
            if (k == 26) chk("held_restart_busy", 32'(bus_a.busy), 1);
        end
        bus_a.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk); #1;
            if (bus_a.done) seen = 1'b1;
        end
        chk("held_second_done", 32'(seen), 1);
        chk("held_second_tt", 32'(bus_a.truth_table), 32'h0EA);
        @(posedge clk); #1;

        // Random functions on either sequencer with random ignored start pulses
        for (int n = 0; n < 10; n++) begin
            ub  = 1'($urandom_range(0, 1));
            f   = 8'($urandom);
            lat = ub ? 16 : 24;
`ifdef TT_CHECK_EN
            golden_tt = f;
`endif
            scan(ub, f, f, int'($urandom_range(1, lat)), int'($urandom_range(1, lat)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
